// File: rtl/bitorder_reorder_pkg.sv
// ---------------------------------------------------------------------------
// bitorder_pkg
// Shared types and constants for the dibit-order corrector.
//   dibit_t          : one 2-bit RMII-style receive symbol
//   DIBITS_PER_BYTE  : dibits that make up one byte (4)
//   byte_buf_t       : one byte as 4 dibits, index 0 = first received (LS)
//   LAST_SLOT        : input counter value of the byte-completing dibit
// ---------------------------------------------------------------------------
package bitorder_pkg;

  localparam int DIBIT_W         = 2;
  localparam int DIBITS_PER_BYTE = 4;

  typedef logic [DIBIT_W-1:0] dibit_t;
  typedef dibit_t [DIBITS_PER_BYTE-1:0] byte_buf_t;

  localparam logic [1:0] LAST_SLOT = 2'(DIBITS_PER_BYTE - 1);

endpackage

// File: rtl/bitorder_reorder_if.sv
// ---------------------------------------------------------------------------
// bitorder_reorder_if
// Dibit stream bus into and out of the dibit-order corrector.
//   axiiv / axiid : input valid / input dibit (LS dibit of each byte first)
//   axiov / axiod : output valid / output dibit (MS dibit of each byte first)
// Modports:
//   master : the side that drives the input stream and observes the output
//   slave  : the corrector itself
// ---------------------------------------------------------------------------
interface bitorder_reorder_if;
  import bitorder_pkg::*;

  logic   axiiv;
  dibit_t axiid;
  logic   axiov;
  dibit_t axiod;

  modport master (output axiiv, output axiid, input axiov, input axiod);
  modport slave  (input axiiv, input axiid, output axiov, output axiod);

endinterface

// File: rtl/bitorder_reorder_dibit_collector.sv
// ---------------------------------------------------------------------------
// dibit_collector
// Gathers incoming dibits into a byte. Slots 0..2 are registered; the 4th
// dibit is passed straight through so the completed byte is available in the
// same cycle it is sampled (byte_done strobe).
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   valid      : input valid; low for any cycle ends the frame
//   dibit      : input dibit
//   byte_done  : high in the cycle the 4th dibit of a byte is present
//   byte_data  : collected byte, [0] = first dibit, [3] = incoming dibit
//   discard    : (BITORDER_PARTIAL_FLAG_EN only) high while a partial byte
//                is being dropped because valid fell
// ---------------------------------------------------------------------------
module dibit_collector
  import bitorder_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      valid,
  input  dibit_t    dibit,
  output logic      byte_done,
  output byte_buf_t byte_data
`ifdef BITORDER_PARTIAL_FLAG_EN
  ,
  output logic      discard
`endif
);

  logic [1:0] icnt_reg;
  dibit_t     slot_reg [0:DIBITS_PER_BYTE-2];

  // Counter wraps 3->0 naturally; a gap in valid restarts collection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      icnt_reg <= 2'd0;
    end else if (valid) begin
      icnt_reg <= icnt_reg + 2'd1;
    end else begin
      icnt_reg <= 2'd0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DIBITS_PER_BYTE - 1; gi++) begin : g_slot
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          slot_reg[gi] <= '0;
        end else if (valid && (icnt_reg == 2'(gi))) begin
          slot_reg[gi] <= dibit;
        end
      end
      assign byte_data[gi] = slot_reg[gi];
    end
  endgenerate

  assign byte_data[DIBITS_PER_BYTE-1] = dibit;
  assign byte_done = valid && (icnt_reg == LAST_SLOT);

`ifdef BITORDER_PARTIAL_FLAG_EN
  assign discard = !valid && (icnt_reg != 2'd0);
`endif

endmodule

// File: rtl/bitorder_reorder.sv
// ---------------------------------------------------------------------------
// bitorder_reorder
// Dibit-order corrector: bytes arrive LS dibit first and leave MS dibit
// first, four consecutive output cycles per byte, no throughput loss.
// The collector holds the input buffer; this level holds the output buffer,
// the drain counter and the output registers (double buffering, so the next
// byte can be collected while the current one drains).
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   bus      : bitorder_reorder_if.slave (axiiv/axiid in, axiov/axiod out)
//   partial  : only with BITORDER_PARTIAL_FLAG_EN defined; one-cycle pulse
//              when a partial byte is discarded at the end of a frame
// Optional feature macro: BITORDER_PARTIAL_FLAG_EN
// ---------------------------------------------------------------------------
module bitorder_reorder
  import bitorder_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  bitorder_reorder_if.slave    bus
`ifdef BITORDER_PARTIAL_FLAG_EN
  ,
  output logic                 partial
`endif
);

  logic      byte_done;
  byte_buf_t byte_data;

  dibit_t     out_buf_reg [0:DIBITS_PER_BYTE-2];
  logic [1:0] drain_reg;      // dibits still to emit after the current one
  logic       axiov_reg;
  dibit_t     axiod_reg;
  dibit_t     drain_dibit;

`ifdef BITORDER_PARTIAL_FLAG_EN
  logic discard;
  logic partial_reg;
`endif

  dibit_collector u_collector (
    .clk       (clk),
    .rst       (rst),
    .valid     (bus.axiiv),
    .dibit     (bus.axiid),
    .byte_done (byte_done),
    .byte_data (byte_data)
`ifdef BITORDER_PARTIAL_FLAG_EN
    ,
    .discard   (discard)
`endif
  );

  // Only slots 0..2 need holding: slot 3 goes straight to the output.
  genvar gi;
  generate
    for (gi = 0; gi < DIBITS_PER_BYTE - 1; gi++) begin : g_out_buf
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          out_buf_reg[gi] <= '0;
        end else if (byte_done) begin
          out_buf_reg[gi] <= byte_data[gi];
        end
      end
    end
  endgenerate

  // drain_reg counts down 3,2,1 selecting slots 2,1,0.
  always_comb begin
    drain_dibit = '0;
    case (drain_reg)
      2'd3:    drain_dibit = out_buf_reg[2];
      2'd2:    drain_dibit = out_buf_reg[1];
      2'd1:    drain_dibit = out_buf_reg[0];
      default: drain_dibit = '0;
    endcase
  end

  // A new byte completes no earlier than the cycle after the previous drain
  // finishes, so byte_done never interrupts a drain with legal input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      axiov_reg <= 1'b0;
      axiod_reg <= '0;
      drain_reg <= 2'd0;
    end else if (byte_done) begin
      axiov_reg <= 1'b1;
      axiod_reg <= byte_data[DIBITS_PER_BYTE-1];
      drain_reg <= LAST_SLOT;
    end else if (drain_reg != 2'd0) begin
      axiov_reg <= 1'b1;
      axiod_reg <= drain_dibit;
      drain_reg <= drain_reg - 2'd1;
    end else begin
      axiov_reg <= 1'b0;
      axiod_reg <= '0;
    end
  end

  assign bus.axiov = axiov_reg;
  assign bus.axiod = axiod_reg;

`ifdef BITORDER_PARTIAL_FLAG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      partial_reg <= 1'b0;
    end else begin
      partial_reg <= discard;
    end
  end

  assign partial = partial_reg;
`endif

endmodule

// File: tb/tb_bitorder_reorder.sv
// ---------------------------------------------------------------------------
// tb_bitorder_reorder
// Directed self-checking bench for bitorder_reorder. Inputs change 1 time
// unit after each rising edge; outputs are checked 1 time unit after the
// edge that produced them. Build with BITORDER_PARTIAL_FLAG_EN to also check
// the partial flag.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bitorder_reorder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  bitorder_reorder_if bus ();

`ifdef BITORDER_PARTIAL_FLAG_EN
  logic partial;
`endif

  bitorder_reorder dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave)
`ifdef BITORDER_PARTIAL_FLAG_EN
    ,
    .partial (partial)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_out(input logic ev, input logic [1:0] ed, input string tag);
    checks++;
    assert (bus.axiov === ev && bus.axiod === ed) else begin
      errors++;
      $display("FAIL %s axiov/axiod got %b/%b want %b/%b", tag, bus.axiov, bus.axiod, ev, ed);
      $error("%s output check", tag);
    end
  endtask

  task automatic check_partial(input logic ep, input string tag);
`ifdef BITORDER_PARTIAL_FLAG_EN
    checks++;
    assert (partial === ep) else begin
      errors++;
      $display("FAIL %s partial got %b want %b", tag, partial, ep);
      $error("%s partial check", tag);
    end
`else
    if (ep === 1'bx) $display("%s", tag);
`endif
  endtask

  // Drive one input cycle, clock it, then check the registered output.
  task automatic step(input logic v, input logic [1:0] d,
                      input logic ev, input logic [1:0] ed, input string tag);
    bus.axiiv = v;
    bus.axiid = d;
    @(posedge clk);
    #1;
    $display("step %s in %b/%b out %b/%b", tag, v, d, bus.axiov, bus.axiod);
    check_out(ev, ed, tag);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    bus.axiiv = 1'b0;
    bus.axiid = 2'b00;

    // Reset state
    #12;
    check_out(1'b0, 2'b00, "reset");
    check_partial(1'b0, "reset_partial");
    #10;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single byte 01,01,01,11 then idle
    step(1, 2'b01, 0, 2'b00, "t1_in0");
    step(1, 2'b01, 0, 2'b00, "t1_in1");
    step(1, 2'b01, 0, 2'b00, "t1_in2");
    step(1, 2'b11, 1, 2'b11, "t1_o0");
    step(0, 2'b00, 1, 2'b01, "t1_o1");
    step(0, 2'b00, 1, 2'b01, "t1_o2");
    step(0, 2'b00, 1, 2'b01, "t1_o3");
    step(0, 2'b00, 0, 2'b00, "t1_end");
    check_partial(1'b0, "t1_partial");

    // Three back-to-back bytes
    step(1, 2'b01, 0, 2'b00, "t2_in0");
    step(1, 2'b01, 0, 2'b00, "t2_in1");
    step(1, 2'b01, 0, 2'b00, "t2_in2");
    step(1, 2'b11, 1, 2'b11, "t2_o0");
    step(1, 2'b00, 1, 2'b01, "t2_o1");
    step(1, 2'b01, 1, 2'b01, "t2_o2");
    step(1, 2'b10, 1, 2'b01, "t2_o3");
    step(1, 2'b10, 1, 2'b10, "t2_o4");
    step(1, 2'b11, 1, 2'b10, "t2_o5");
    step(1, 2'b00, 1, 2'b01, "t2_o6");
    step(1, 2'b11, 1, 2'b00, "t2_o7");
    step(1, 2'b01, 1, 2'b01, "t2_o8");
    step(0, 2'b00, 1, 2'b11, "t2_o9");
    step(0, 2'b00, 1, 2'b00, "t2_o10");
    step(0, 2'b00, 1, 2'b11, "t2_o11");
    step(0, 2'b00, 0, 2'b00, "t2_end");

    // One byte plus two dibits, partial discarded
    step(1, 2'b01, 0, 2'b00, "t3_in0");
    step(1, 2'b01, 0, 2'b00, "t3_in1");
    step(1, 2'b01, 0, 2'b00, "t3_in2");
    step(1, 2'b11, 1, 2'b11, "t3_o0");
    step(1, 2'b00, 1, 2'b01, "t3_o1");
    check_partial(1'b0, "t3_partial_pre");
    step(1, 2'b01, 1, 2'b01, "t3_o2");
    step(0, 2'b00, 1, 2'b01, "t3_o3");
    check_partial(1'b1, "t3_partial_pulse");
    step(0, 2'b00, 0, 2'b00, "t3_end0");
    check_partial(1'b0, "t3_partial_clear");
    step(0, 2'b00, 0, 2'b00, "t3_end1");
    step(0, 2'b00, 0, 2'b00, "t3_end2");

    // Reset asserted during the 2nd output dibit
    step(1, 2'b01, 0, 2'b00, "t4_in0");
    step(1, 2'b01, 0, 2'b00, "t4_in1");
    step(1, 2'b01, 0, 2'b00, "t4_in2");
    step(1, 2'b11, 1, 2'b11, "t4_o0");
    step(0, 2'b00, 1, 2'b01, "t4_o1");
    #2;
    rst = 1'b0;
    #1;
    check_out(1'b0, 2'b00, "t4_async_rst");
    @(posedge clk);
    #4;
    rst = 1'b1;
    #2;
    check_out(1'b0, 2'b00, "t4_rst_release");
    @(posedge clk);
    #1;
    check_out(1'b0, 2'b00, "t4_post0");
    step(0, 2'b00, 0, 2'b00, "t4_post1");
    step(0, 2'b00, 0, 2'b00, "t4_post2");
    step(0, 2'b00, 0, 2'b00, "t4_post3");

    // One-cycle gap between two full bytes
    step(1, 2'b01, 0, 2'b00, "t5_in0");
    step(1, 2'b01, 0, 2'b00, "t5_in1");
    step(1, 2'b01, 0, 2'b00, "t5_in2");
    step(1, 2'b11, 1, 2'b11, "t5_a0");
    step(0, 2'b00, 1, 2'b01, "t5_a1");
    step(1, 2'b00, 1, 2'b01, "t5_a2");
    step(1, 2'b01, 1, 2'b01, "t5_a3");
    step(1, 2'b10, 0, 2'b00, "t5_gap");
    step(1, 2'b10, 1, 2'b10, "t5_b0");
    step(0, 2'b00, 1, 2'b10, "t5_b1");
    step(0, 2'b00, 1, 2'b01, "t5_b2");
    step(0, 2'b00, 1, 2'b00, "t5_b3");
    step(0, 2'b00, 0, 2'b00, "t5_end");
    check_partial(1'b0, "t5_partial");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
